// File: rtl/reg_mask_pipe_pkg.sv
// Shared types and the per-bit combine function for reg_mask_pipe.
package reg_mask_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_AND_INV = 2'b00,
        MODE_OR      = 2'b01,
        MODE_XOR     = 2'b10,
        MODE_AND     = 2'b11
    } mode_e;

    // Per-bit so it works at any WIDTH; mask is the stored ~I1, so MODE_AND undoes the inversion.
    function automatic logic combine_bit(input mode_e mode, input logic mask, input logic data);
        logic r;
        case (mode)
            MODE_AND_INV: r = mask & data;
            MODE_OR:      r = mask | data;
            MODE_XOR:     r = mask ^ data;
            MODE_AND:     r = ~mask & data;
            default:      r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/reg_mask_stage.sv
// One pipeline stage: mask/mode/valid registers with flush (priority) and advance.
module reg_mask_stage
    import reg_mask_pipe_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             i_adv,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_mask,
    input  mode_e            i_mode,
    input  logic             i_vld,
    output logic [WIDTH-1:0] o_mask,
    output mode_e            o_mode,
    output logic             o_vld
);

    logic [WIDTH-1:0] r_mask;
    mode_e            r_mode;
    logic             r_vld;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_mask <= '0;
            r_mode <= MODE_AND_INV;
            r_vld  <= 1'b0;
        end else if (i_flush) begin
            r_mask <= '0;
            r_mode <= MODE_AND_INV;
            r_vld  <= 1'b0;
        end else if (i_adv) begin
            r_mask <= i_mask;
            r_mode <= i_mode;
            r_vld  <= i_vld;
        end
    end

    assign o_mask = r_mask;
    assign o_mode = r_mode;
    assign o_vld  = r_vld;

endmodule

// File: rtl/reg_mask_pipe.sv
// DEPTH-stage registered mask pipe with per-entry combine mode, hold and flush.
// Optional occupancy counter output OCC when REG_MASK_PIPE_OCC_EN is defined.
module reg_mask_pipe
    import reg_mask_pipe_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             IN_VLD,
    input  logic [1:0]       MODE,
    input  logic             HOLD,
    input  logic             FLUSH,
    output logic [WIDTH-1:0] O0,
    output logic [WIDTH-1:0] O1,
    output logic             O1_VLD
`ifdef REG_MASK_PIPE_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] OCC
`endif
);

    logic [WIDTH-1:0] w_mask [DEPTH];
    mode_e            w_mode [DEPTH];
    logic             w_vld  [DEPTH];
    logic             w_adv;

    assign w_adv = ~HOLD;
    assign O0    = I0 | I1;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            reg_mask_stage #(.WIDTH(WIDTH)) u_stage (
                .CLK     (CLK),
                .RST_N   (RST_N),
                .i_adv   (w_adv),
                .i_flush (FLUSH),
                .i_mask  (~I1),
                .i_mode  (mode_e'(MODE)),
                .i_vld   (IN_VLD),
                .o_mask  (w_mask[k]),
                .o_mode  (w_mode[k]),
                .o_vld   (w_vld[k])
            );
        end else begin : g_body
            reg_mask_stage #(.WIDTH(WIDTH)) u_stage (
                .CLK     (CLK),
                .RST_N   (RST_N),
                .i_adv   (w_adv),
                .i_flush (FLUSH),
                .i_mask  (w_mask[k-1]),
                .i_mode  (w_mode[k-1]),
                .i_vld   (w_vld[k-1]),
                .o_mask  (w_mask[k]),
                .o_mode  (w_mode[k]),
                .o_vld   (w_vld[k])
            );
        end
    end

    // I0 is used live, not registered.
    always_comb begin
        O1 = '0;
        if (w_vld[DEPTH-1]) begin
            for (int b = 0; b < WIDTH; b++) begin
                O1[b] = combine_bit(w_mode[DEPTH-1], w_mask[DEPTH-1][b], I0[b]);
            end
        end
    end

    assign O1_VLD = w_vld[DEPTH-1];

`ifdef REG_MASK_PIPE_OCC_EN
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [OCC_W-1:0] r_occ;
    logic [OCC_W-1:0] w_occ_nxt;

    // Each advance adds the entering valid and drops the one leaving the last stage.
    always_comb begin
        w_occ_nxt = r_occ + OCC_W'(IN_VLD) - OCC_W'(w_vld[DEPTH-1]);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_occ <= '0;
        end else if (FLUSH) begin
            r_occ <= '0;
        end else if (w_adv) begin
            r_occ <= w_occ_nxt;
        end
    end

    assign OCC = r_occ;
`endif

endmodule
